// File: rtl/arith_pkg.sv
// Shared constants and state encoding for the
// bit-serial arithmetic blocks.
package arith_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder, table form
// like the subtractor cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  always_comb begin
    s = 1'b0;
    c = 1'b0;
    unique case ({a, b, cin})
      3'b000: begin s = 1'b0; c = 1'b0; end
      3'b001: begin s = 1'b1; c = 1'b0; end
      3'b010: begin s = 1'b1; c = 1'b0; end
      3'b011: begin s = 1'b0; c = 1'b1; end
      3'b100: begin s = 1'b1; c = 1'b0; end
      3'b101: begin s = 1'b0; c = 1'b1; end
      3'b110: begin s = 1'b0; c = 1'b1; end
      3'b111: begin s = 1'b1; c = 1'b1; end
      default: begin s = 1'b0; c = 1'b0; end
    endcase
  end

endmodule

// File: rtl/serial_fa_adder.sv
// Bit-serial adder: one full-adder cell plus a
// carry flop, LSB first, sum shifted in from MSB.
module serial_fa_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           fa_s, fa_c;

  fa_cell u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = fa_c;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_fa_adder.sv
// Directed bench for serial_fa_adder at WIDTH=8
// and WIDTH=4.
module tb_serial_fa_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_fa_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done),
    .sum(sum), .cout(cout)
  );

  serial_fa_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4),
    .sum(sum4), .cout(cout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(
    input  logic [7:0] ia,
    input  logic [7:0] ib,
    input  logic       ic,
    output int         lat,
    output int         busy_n,
    output logic [7:0] s,
    output logic       co,
    output logic       done_after
  );
    a = ia; b = ib; cin = ic; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ia; b = ~ib; cin = ~ic;
    lat = 0; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    s = sum; co = cout;
    tick();
    done_after = done;
  endtask

  task automatic check_op(
    input string       nm,
    input logic [7:0]  ia,
    input logic [7:0]  ib,
    input logic        ic,
    input logic [7:0]  exp_s,
    input logic        exp_c
  );
    int lat, bn;
    logic [7:0] s;
    logic co, da;
    do_op(ia, ib, ic, lat, bn, s, co, da);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL %s latency got=%0d want=8", nm, lat);
    end
    total++;
    if (bn !== 8) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d want=8", nm, bn);
    end
    total++;
    if (s !== exp_s || co !== exp_c) begin
      bad++;
      $display("FAIL %s result got=%0b/%h want=%0b/%h",
               nm, co, s, exp_c, exp_s);
    end
    total++;
    if (da !== 1'b0) begin
      bad++;
      $display("FAIL %s done_width got=%b want=0", nm, da);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start4 = 1'b1;
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    tick();
    tick();
    start = 1'b0; start4 = 1'b0;
    total++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      bad++;
      $display("FAIL reset got=%b%b%b/%h want=000/00",
               busy, done, cout, sum);
    end
    total++;
    if ({busy4, done4, cout4, sum4} !== 7'd0) begin
      bad++;
      $display("FAIL reset4 got=%b%b%b/%h want=000/0",
               busy4, done4, cout4, sum4);
    end
    rst = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_start got=%b want=0", busy);
    end
  endtask

  task automatic test_basic();
    check_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
  endtask

  task automatic test_overflow();
    check_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    check_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    check_op("add_00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
  endtask

  task automatic test_roundtrip();
    check_op("roundtrip", 8'h23, 8'h12, 1'b0, 8'h35, 1'b0);
  endtask

  task automatic test_ignore_start();
    int dn;
    logic [7:0] s;
    logic co;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0; s = '0; co = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        dn++;
        s = sum;
        co = cout;
      end
      tick();
    end
    total++;
    if (dn !== 1) begin
      bad++;
      $display("FAIL ignore_pulses got=%0d want=1", dn);
    end
    total++;
    if (s !== 8'h30 || co !== 1'b0) begin
      bad++;
      $display("FAIL ignore_result got=%b/%h want=0/30", co, s);
    end
  endtask

  task automatic test_reset_abort();
    int dn;
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      bad++;
      $display("FAIL abort_state got=%b%b%b/%h want=000/00",
               busy, done, cout, sum);
    end
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dn++;
      tick();
    end
    total++;
    if (dn !== 0) begin
      bad++;
      $display("FAIL abort_quiet got=%0d want=0", dn);
    end
    check_op("after_abort", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
  endtask

  task automatic test_back_to_back();
    int dn, last, gap_bad, val_bad, wt;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    dn = 0; last = -1; gap_bad = 0; val_bad = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (done) begin
        if (sum !== 8'h02 || cout !== 1'b0) val_bad++;
        if (last >= 0 && cyc - last != 10) gap_bad++;
        last = cyc;
        dn++;
      end
    end
    start = 1'b0;
    total++;
    if (dn !== 4) begin
      bad++;
      $display("FAIL b2b_pulses got=%0d want=4", dn);
    end
    total++;
    if (gap_bad !== 0) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want=0", gap_bad);
    end
    total++;
    if (val_bad !== 0) begin
      bad++;
      $display("FAIL b2b_sum got=%0d want=0", val_bad);
    end
    wt = 0;
    while ((busy || done) && wt < 20) begin
      tick();
      wt++;
    end
    total++;
    if (wt >= 20) begin
      bad++;
      $display("FAIL b2b_idle got=busy want=idle");
    end
  endtask

  task automatic test_width4();
    int lat;
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = 4'h0; b4 = 4'h0;
    lat = 0;
    while (!done4 && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL w4_latency got=%0d want=4", lat);
    end
    total++;
    if (sum4 !== 4'h0 || cout4 !== 1'b1) begin
      bad++;
      $display("FAIL w4_result got=%b/%h want=1/0",
               cout4, sum4);
    end
    tick();
    total++;
    if (done4 !== 1'b0) begin
      bad++;
      $display("FAIL w4_done_width got=%b want=0", done4);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_roundtrip();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_width4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
